// File: rtl/attention_av_stream_ctrl.sv
// Streams precision codes, A and V into engine-facing registers, starts the AV multiply
// and drains Z one element per handshake. Define AV_PREC_CLAMP_EN to clamp precision codes to 2.
module attention_av_stream_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int L          = 8,
   parameter int N          = 1,
   parameter int E          = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DATA_WIDTH-1:0]          in_data,
   output logic                           mm_start,
   input  logic                           mm_done,
   output logic [DATA_WIDTH*L*N*L-1:0]    A_out,
   output logic [DATA_WIDTH*L*N*E-1:0]    V_out,
   output logic [3:0]                     prec_out [L-1:0],
   input  logic [DATA_WIDTH*L*N*E-1:0]    Z_in,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DATA_WIDTH-1:0]          out_data,
   output logic                           out_last,
   output logic                           busy
);

   localparam int NA   = L * N * L;
   localparam int NV   = L * N * E;
   localparam int NMAX = (L > NA) ? ((L > NV) ? L : NV) : ((NA > NV) ? NA : NV);
   localparam int CW   = $clog2(NMAX + 1);

   typedef enum logic [2:0] {S_PREC, S_A, S_V, S_START, S_WAIT, S_DRAIN} state_t;

   state_t                       r_state;
   state_t                       w_state_next;
   logic [CW-1:0]                r_cnt;
   logic [CW-1:0]                w_cnt_next;
   logic                         w_in_xfer;
   logic                         w_z_capture;
   logic [3:0]                   w_prec_val;
   logic [3:0]                   r_prec [L];
   logic [DATA_WIDTH*NA-1:0]     r_a;
   logic [DATA_WIDTH*NV-1:0]     r_v;
   logic [DATA_WIDTH*NV-1:0]     r_z;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_PREC;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      in_ready     = 1'b0;
      mm_start     = 1'b0;
      out_valid    = 1'b0;
      out_last     = 1'b0;
      w_z_capture  = 1'b0;
      case (r_state)
         S_PREC: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (r_cnt == CW'(L - 1)) begin
                  w_state_next = S_A;
                  w_cnt_next   = '0;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
         end
         S_A: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (r_cnt == CW'(NA - 1)) begin
                  w_state_next = S_V;
                  w_cnt_next   = '0;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
         end
         S_V: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (r_cnt == CW'(NV - 1)) begin
                  w_state_next = S_START;
                  w_cnt_next   = '0;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
         end
         S_START: begin
            mm_start     = 1'b1;
            w_state_next = S_WAIT;
         end
         S_WAIT: begin
            if (mm_done) begin
               w_z_capture  = 1'b1;
               w_state_next = S_DRAIN;
               w_cnt_next   = '0;
            end
         end
         S_DRAIN: begin
            out_valid = 1'b1;
            out_last  = (r_cnt == CW'(NV - 1));
            if (out_ready) begin
               if (r_cnt == CW'(NV - 1)) begin
                  w_state_next = S_PREC;
                  w_cnt_next   = '0;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_next = S_PREC;
            w_cnt_next   = '0;
         end
      endcase
   end

   assign w_in_xfer = in_valid && in_ready;
   // Idle means "waiting for the first precision beat"; everything else counts as busy.
   assign busy      = !((r_state == S_PREC) && (r_cnt == '0));

   always_comb begin
`ifdef AV_PREC_CLAMP_EN
      w_prec_val = (in_data[3:0] > 4'd2) ? 4'd2 : in_data[3:0];
`else
      w_prec_val = in_data[3:0];
`endif
   end

   generate
      for (genvar gi = 0; gi < L; gi++) begin : g_prec
         always_ff @(posedge clk) begin
            if (rst) begin
               r_prec[gi] <= 4'd0;
            end else if (w_in_xfer && (r_state == S_PREC) && (r_cnt == CW'(gi))) begin
               r_prec[gi] <= w_prec_val;
            end
         end
         assign prec_out[gi] = r_prec[gi];
      end
   endgenerate

   // Matrix and Z storage carry no reset: contents are always rewritten before use.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NA; i++) begin
         if (w_in_xfer && (r_state == S_A) && (r_cnt == CW'(i))) begin
            r_a[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
         end
      end
      for (int i = 0; i < NV; i++) begin
         if (w_in_xfer && (r_state == S_V) && (r_cnt == CW'(i))) begin
            r_v[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
         end
      end
      if (w_z_capture) begin
         r_z <= Z_in;
      end
   end

   assign A_out = r_a;
   assign V_out = r_v;

   always_comb begin
      out_data = '0;
      for (int i = 0; i < NV; i++) begin
         if (r_cnt == CW'(i)) begin
            out_data = r_z[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_attention_av_stream_ctrl.sv
// Directed bench for attention_av_stream_ctrl: precision table, full frames with
// gaps/stalls, spurious engine pulses and mid-drain reset.
module tb_attention_av_stream_ctrl;

   localparam int DW = 16;
   localparam int L  = 8;
   localparam int N  = 1;
   localparam int E  = 8;
   localparam int NA = L * N * L;
   localparam int NV = L * N * E;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     in_data;
   logic              mm_start;
   logic              mm_done;
   logic [DW*NA-1:0]  A_out;
   logic [DW*NV-1:0]  V_out;
   logic [3:0]        prec_out [L-1:0];
   logic [DW*NV-1:0]  Z_in;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_data;
   logic              out_last;
   logic              busy;

   logic              eng_done;
   logic              tb_done;
   int                cyc = 0;
   int                done_cyc = 0;
   int                n_start = 0;
   int                last_cyc = 0;
   int                first_cyc = 0;
   int                n_cmp = 0;
   int                n_err = 0;

   typedef struct {
      logic [15:0] din;
      logic [3:0]  exp;
   } prec_vec_t;
   prec_vec_t pv [L];

   assign mm_done = eng_done | tb_done;

   attention_av_stream_ctrl #(.DATA_WIDTH(DW), .L(L), .N(N), .E(E)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .mm_start(mm_start), .mm_done(mm_done),
      .A_out(A_out), .V_out(V_out), .prec_out(prec_out), .Z_in(Z_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mm_start) n_start <= n_start + 1;
   end

   // Engine model: completion pulse roughly ten cycles after each start.
   initial begin
      eng_done = 1'b0;
      forever begin
         @(negedge clk);
         if (mm_start) begin
            repeat (9) @(negedge clk);
            eng_done = 1'b1;
            done_cyc = cyc;
            @(negedge clk);
            eng_done = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] aval(input logic [15:0] b, input int k);
      return b + 16'(k * 5) + 16'h0100;
   endfunction

   function automatic logic [15:0] vval(input logic [15:0] b, input int k);
      return (b ^ 16'h5A5A) + 16'(k * 11);
   endfunction

   function automatic logic [15:0] zval(input logic [15:0] b, input int k);
      return b + 16'(k * 37);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic send(input logic [15:0] d, input bit gaps);
      int t;
      int g;
      if (gaps) begin
         g = $urandom_range(0, 2);
         repeat (g) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 16'hDEAD;
         end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: in_ready stuck at 0 for data %0h", d);
      end else begin
         last_cyc = cyc;
      end
      @(posedge clk);
   endtask

   task automatic check_av(input logic [15:0] seed);
      for (int i = 0; i < NA; i++)
         check($sformatf("A_elem_%0d", i), 32'(A_out[i*DW +: DW]), 32'(aval(seed, i)));
      for (int i = 0; i < NV; i++)
         check($sformatf("V_elem_%0d", i), 32'(V_out[i*DW +: DW]), 32'(vval(seed, i)));
   endtask

   task automatic run_frame(input logic [15:0] seed, input logic [15:0] zbase,
                            input bit gaps, input bit stalls, input bit poke, input int rst_at);
      int  start_cnt;
      int  t;
      int  k;
      bit  tampered;
      bit  first;
      for (int i = 0; i < NV; i++) Z_in[i*DW +: DW] = zval(zbase, i);
      start_cnt = n_start;

      for (int i = 0; i < L; i++) begin
         send(pv[i].din, gaps);
         if (i == 0) first_cyc = last_cyc;
      end
      for (int i = 0; i < NA; i++) begin
         send(aval(seed, i), gaps);
         if (poke && i == 5) begin
            @(negedge clk);
            in_valid = 1'b0;
            tb_done  = 1'b1;
            @(negedge clk);
            tb_done = 1'b0;
            check("sa_done_in_ready", 32'(in_ready), 32'd1);
            check("sa_done_out_valid", 32'(out_valid), 32'd0);
            check("sa_done_no_start", 32'(n_start - start_cnt), 32'd0);
         end
      end
      for (int i = 0; i < NV; i++) send(vval(seed, i), gaps);
      if (!gaps) check("load_cycles", 32'(last_cyc - first_cyc + 1), 32'(L + NA + NV));

      @(negedge clk);
      in_valid = poke;
      in_data  = 16'hBEEF;
      check("mm_start_pulse", 32'(mm_start), 32'd1);
      @(negedge clk);
      check("mm_start_low", 32'(mm_start), 32'd0);
      check("wait_in_ready", 32'(in_ready), 32'd0);
      check("wait_busy", 32'(busy), 32'd1);
      for (int i = 0; i < L; i++)
         check($sformatf("prec_%0d", i), 32'(prec_out[i]), 32'(pv[i].exp));
      check_av(seed);

      k = 0;
      t = 0;
      tampered = 1'b0;
      first = 1'b1;
      while (k < NV && t < 1000) begin
         @(negedge clk);
         t++;
         tb_done = 1'b0;
         out_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
         if (!out_valid) begin
            if (in_valid) check("wait_in_ready_poke", 32'(in_ready), 32'd0);
         end else begin
            if (first) begin
               check("first_valid_cycle", 32'(cyc), 32'(done_cyc + 1));
               first = 1'b0;
               in_valid = 1'b0;
            end
            check($sformatf("out_data_%0d", k), 32'(out_data), 32'(zval(zbase, k)));
            check($sformatf("out_last_%0d", k), 32'(out_last), 32'(k == NV - 1));
            if (k == rst_at) begin
               out_ready = 1'b1;
               rst = 1'b1;
               @(negedge clk);
               check("rst_out_valid", 32'(out_valid), 32'd0);
               check("rst_out_last", 32'(out_last), 32'd0);
               check("rst_in_ready", 32'(in_ready), 32'd1);
               check("rst_busy", 32'(busy), 32'd0);
               check("rst_mm_start", 32'(mm_start), 32'd0);
               check("rst_prec_clear", 32'(prec_out[1]), 32'd0);
               rst = 1'b0;
               return;
            end
            if (poke && k == 10 && !tampered) begin
               tampered = 1'b1;
               tb_done  = 1'b1;
               Z_in     = ~Z_in;
            end
            if (out_ready) k++;
         end
      end
      if (k < NV) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: only %0d of %0d beats", k, NV);
      end
      @(negedge clk);
      tb_done = 1'b0;
      check("post_out_valid", 32'(out_valid), 32'd0);
      check("post_out_last", 32'(out_last), 32'd0);
      check("post_busy", 32'(busy), 32'd0);
      check("post_in_ready", 32'(in_ready), 32'd1);
      check("start_count", 32'(n_start - start_cnt), 32'd1);
      check_av(seed);
   endtask

   initial begin
      pv[0].din = 16'hAB30; pv[1].din = 16'h0011; pv[2].din = 16'hFFF2; pv[3].din = 16'h0003;
      pv[4].din = 16'h123F; pv[5].din = 16'h0000; pv[6].din = 16'h8001; pv[7].din = 16'h0002;
`ifdef AV_PREC_CLAMP_EN
      pv[0].exp = 4'd0; pv[1].exp = 4'd1; pv[2].exp = 4'd2; pv[3].exp = 4'd2;
      pv[4].exp = 4'd2; pv[5].exp = 4'd0; pv[6].exp = 4'd1; pv[7].exp = 4'd2;
`else
      pv[0].exp = 4'd0; pv[1].exp = 4'd1; pv[2].exp = 4'd2; pv[3].exp = 4'd3;
      pv[4].exp = 4'd15; pv[5].exp = 4'd0; pv[6].exp = 4'd1; pv[7].exp = 4'd2;
`endif
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      tb_done   = 1'b0;
      Z_in      = '0;
      repeat (3) @(negedge clk);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_last", 32'(out_last), 32'd0);
      check("reset_mm_start", 32'(mm_start), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      for (int i = 0; i < L; i++)
         check($sformatf("reset_prec_%0d", i), 32'(prec_out[i]), 32'd0);
      rst = 1'b0;
      check("reset_in_ready", 32'(in_ready), 32'd1);

      run_frame(16'h1000, 16'h4000, 1'b0, 1'b0, 1'b0, -1);
      $display("frame 1 done: back-to-back, cmp=%0d err=%0d", n_cmp, n_err);
      run_frame(16'h2200, 16'h8100, 1'b1, 1'b1, 1'b1, -1);
      $display("frame 2 done: gaps/stalls/spurious done, cmp=%0d err=%0d", n_cmp, n_err);
      run_frame(16'h3300, 16'hC000, 1'b0, 1'b0, 1'b0, 20);
      $display("frame 3 done: reset at drain beat 20, cmp=%0d err=%0d", n_cmp, n_err);
      run_frame(16'h4400, 16'h0123, 1'b0, 1'b1, 1'b0, -1);
      $display("frame 4 done: recovery frame, cmp=%0d err=%0d", n_cmp, n_err);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
